sw_debounce: RTL and testbench
==============================

Name: sw_debounce

Overview:
- Per-bit switch debouncer that sits directly upstream of the switch PIO input port.
- Synchronises the raw, asynchronous, bouncing slide-switch/push-button lines into the clk domain.
- Filters the lines with a shared tick prescaler and a per-bit stability counter.
- Presents clean levels on sw_out, which is wired straight to the PIO in_port, so the PIO edge capture sees exactly one edge per physical switch action.

Parameters:
- WIDTH, 14, number of switch lines.
- CLK_DIV, 50000, clk cycles per debounce tick (1 ms at 50 MHz); legal range >= 1.
- STABLE_TICKS, 10, consecutive ticks a changed input must stay stable before sw_out follows; legal range >= 1.
- RESET_VAL, 0, WIDTH-bit value loaded into sync flops and sw_out at reset.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- sw_raw  input  WIDTH  raw switch lines, asynchronous to clk.
- bypass  input  1  1 = skip filtering (sw_out follows the synchronised input); must be quasi-static.
- sw_out  output  WIDTH  debounced levels, registered; feeds PIO in_port.
- tick  output  1  one-cycle prescaler strobe, for debug/scope.
- sw_changed  output  WIDTH  one-cycle per-bit change strobe; present only with SW_DEBOUNCE_PULSE_EN.

Behaviour:
- Reset is asynchronous, active-high, and applies any time, including mid-count:
  - sync stage 1/2 = RESET_VAL, sw_out = RESET_VAL.
  - All per-bit counters = 0, prescaler = 0, tick = 0, sw_changed = 0.
  - After release, a pending change needs a full STABLE_TICKS again.
- Synchroniser: two flops per bit, s = stage-2 output. No other logic reads sw_raw.
- Prescaler:
  - Counter width clog2(CLK_DIV), minimum 1 bit.
  - Counts 0..CLK_DIV-1 and wraps to 0.
  - tick is registered and high for exactly the one cycle after the counter reaches CLK_DIV-1.
  - With CLK_DIV=1, tick is high every cycle after reset release.
  - The prescaler free-runs regardless of bypass.
- Per-bit counter (width clog2(STABLE_TICKS+1)), evaluated each clk:
  - s[i]==sw_out[i]: cnt[i] <= 0. A glitch that returns before the threshold discards all progress.
  - s[i]!=sw_out[i] and tick and cnt[i]==STABLE_TICKS-1: sw_out[i] <= s[i], cnt[i] <= 0.
  - s[i]!=sw_out[i] and tick otherwise: cnt[i] <= cnt[i]+1.
  - s[i]!=sw_out[i] and no tick: hold.
- Latency, for a clean step on sw_raw:
  - 2 cycles of synchroniser, then sw_out updates on the STABLE_TICKS-th tick seen while mismatched.
  - Total between 2+(STABLE_TICKS-1)*CLK_DIV+1 and 2+STABLE_TICKS*CLK_DIV+1 clk cycles.
- Bits are fully independent. Simultaneous changes on several bits with identical timing update sw_out in the same cycle.
- Counter cannot overflow: it is cleared at threshold.
- Bypass:
  - bypass=1: sw_out <= s every cycle and all cnt held at 0.
  - Leaving bypass: filtering restarts from cnt=0.

Optional Feature:
- Macro: SW_DEBOUNCE_PULSE_EN.
- Defined:
  - sw_changed port exists.
  - sw_changed[i] is high for exactly one cycle, the cycle after sw_out[i] changes (both directions, including bypass updates).
  - Reset value 0.
  - Simultaneous bit changes give simultaneous strobes.
- Undefined:
  - Port and its registers are absent.
  - sw_out behaviour is identical either way.

Test Plan (CLK_DIV=4, STABLE_TICKS=3, RESET_VAL=0, unless stated):
- Reset hold, sw_raw=14'h3FFF during reset -> sw_out=0, tick=0 throughout reset; sw_out becomes 14'h3FFF 11..15 cycles after release.
- Clean step: sw_raw[0] 0->1 at cycle 100, held -> sw_out[0] rises in cycles 111..115, exactly once; other bits stay 0.
- Bounce: sw_raw[3] toggles every 5 cycles for 60 cycles, then settles at 1 -> sw_out[3] unchanged during bouncing; rises 11..15 cycles after the last toggle.
- Simultaneous / reset mid-operation: bits 0 and 13 step in the same cycle -> both sw_out bits change in the same cycle. Separately, assert reset when cnt=2 -> sw_out returns to 0 asynchronously; after release a full 11..15 cycle delay applies.
- Bypass and CLK_DIV=1 build: bypass=1, sw_raw=14'h0A5A -> sw_out=14'h0A5A exactly 3 cycles later. CLK_DIV=1, STABLE_TICKS=1 -> any held change passes in 3..4 cycles; tick is continuously high.
- SW_DEBOUNCE_PULSE_EN build: bit 5 rises then later falls -> sw_changed[5] is one single-cycle pulse the cycle after each sw_out[5] transition; no pulses during bouncing.

Source files
------------

// File: rtl/sw_debounce.sv
// sw_debounce: two-flop synchroniser plus a shared tick prescaler and per-bit stability filter.
// Optional macro SW_DEBOUNCE_PULSE_EN adds sw_changed, a one-cycle per-bit change strobe.
module sw_debounce #(
  parameter int unsigned      WIDTH        = 14,
  parameter int unsigned      CLK_DIV      = 50000,
  parameter int unsigned      STABLE_TICKS = 10,
  parameter logic [WIDTH-1:0] RESET_VAL    = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_raw,
  input  logic             bypass,
  output logic [WIDTH-1:0] sw_out,
  output logic             tick
`ifdef SW_DEBOUNCE_PULSE_EN
  ,
  output logic [WIDTH-1:0] sw_changed
`endif
);

  localparam int unsigned    PW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned    CW      = $clog2(STABLE_TICKS + 1);
  localparam logic [PW-1:0]  PRE_MAX = PW'(CLK_DIV - 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE_TICKS - 1);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [PW-1:0]    r_pre;
  logic             r_tick;
  logic [CW-1:0]    r_cnt     [WIDTH];
  logic [CW-1:0]    w_cnt_nxt [WIDTH];
  logic [WIDTH-1:0] r_sw_out;
  logic [WIDTH-1:0] w_sw_out_nxt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= RESET_VAL;
      r_sync2 <= RESET_VAL;
    end else begin
      r_sync1 <= sw_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Free-running prescaler; tick is the registered wrap strobe, independent of bypass.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pre  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= (r_pre == PRE_MAX);
      r_pre  <= (r_pre == PRE_MAX) ? '0 : r_pre + PW'(1);
    end
  end

  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    w_sw_out_nxt = r_sw_out;
    w_cnt_nxt    = r_cnt;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (bypass) begin
        w_sw_out_nxt[i] = r_sync2[i];
        w_cnt_nxt[i]    = '0;
      end else if (r_sync2[i] == r_sw_out[i]) begin
        w_cnt_nxt[i] = '0;
      end else if (r_tick) begin
        if (r_cnt[i] == CNT_MAX) begin
          w_sw_out_nxt[i] = r_sync2[i];
          w_cnt_nxt[i]    = '0;
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sw_out <= RESET_VAL;
      r_cnt    <= '{default: '0};
    end else begin
      r_sw_out <= w_sw_out_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  assign sw_out = r_sw_out;
  assign tick   = r_tick;

`ifdef SW_DEBOUNCE_PULSE_EN
  logic [WIDTH-1:0] r_sw_changed;

  // Strobe is high during the first cycle sw_out shows its new value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_sw_changed <= '0;
    else       r_sw_changed <= w_sw_out_nxt ^ r_sw_out;
  end

  assign sw_changed = r_sw_changed;
`endif

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce: one instance with CLK_DIV=4/STABLE_TICKS=3, one with CLK_DIV=1/STABLE_TICKS=1.
`timescale 1ns/1ps
module tb_sw_debounce;

  localparam int W = 14;

  logic         clk      = 1'b0;
  logic         reset    = 1'b1;
  logic         bypass   = 1'b0;
  logic         bypass_b = 1'b0;
  logic [W-1:0] sw_raw   = '0;
  logic [W-1:0] sw_raw_b = '0;
  logic [W-1:0] sw_out, sw_out_b;
  logic         tick, tick_b;
`ifdef SW_DEBOUNCE_PULSE_EN
  logic [W-1:0] sw_changed, sw_changed_b;
  int           n_pulse5 = 0;
  int           n_bad5   = 0;
  logic         last5    = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sw_debounce #(.WIDTH(W), .CLK_DIV(4), .STABLE_TICKS(3), .RESET_VAL(14'h0)) dut (
    .clk(clk), .reset(reset), .sw_raw(sw_raw), .bypass(bypass),
    .sw_out(sw_out), .tick(tick)
`ifdef SW_DEBOUNCE_PULSE_EN
    , .sw_changed(sw_changed)
`endif
  );

  sw_debounce #(.WIDTH(W), .CLK_DIV(1), .STABLE_TICKS(1), .RESET_VAL(14'h0)) dut_b (
    .clk(clk), .reset(reset), .sw_raw(sw_raw_b), .bypass(bypass_b),
    .sw_out(sw_out_b), .tick(tick_b)
`ifdef SW_DEBOUNCE_PULSE_EN
    , .sw_changed(sw_changed_b)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    if (obs !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, want);
    end
  endtask

  // Sample 1 ns after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Count edges until sw_out leaves 'old'; 999 marks a timeout.
  task automatic wait_chg(input logic [W-1:0] old, output int cyc);
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (sw_out == old && cyc < 40);
    if (sw_out == old) cyc = 999;
    $display("info: sw_out 0x%0h -> 0x%0h after %0d cycles", old, sw_out, cyc);
  endtask

`ifdef SW_DEBOUNCE_PULSE_EN
  task automatic watch5(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      step();
      if (sw_changed[5] !== (sw_out[5] ^ last5)) n_bad5++;
      n_pulse5 += int'(sw_changed[5]);
      last5 = sw_out[5];
    end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int           cyc;
    int           n;
    logic [W-1:0] prev;
    logic         seen;

    // Reset hold with all switches on.
    sw_raw = 14'h3FFF;
    for (int i = 0; i < 4; i++) begin
      step();
      check("rst_sw_out", 32'(sw_out), 32'h0);
      check("rst_tick", 32'(tick), 32'h0);
    end
    reset = 1'b0;
    wait_chg(14'h0, cyc);
    check("rel_latency_11_15", 32'(cyc >= 11 && cyc <= 15), 32'h1);
    check("rel_value", 32'(sw_out), 32'h3FFF);

    sw_raw = 14'h0;
    wait_chg(14'h3FFF, cyc);
    check("clear_latency_11_15", 32'(cyc >= 11 && cyc <= 15), 32'h1);
    check("clear_value", 32'(sw_out), 32'h0);

    // Clean step on bit 0, then confirm no further edges.
    repeat (7) step();
    sw_raw[0] = 1'b1;
    wait_chg(14'h0, cyc);
    check("step0_latency_11_15", 32'(cyc >= 11 && cyc <= 15), 32'h1);
    check("step0_value", 32'(sw_out), 32'h0001);
    prev = sw_out;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (sw_out != prev) n++;
      prev = sw_out;
    end
    check("step0_single_edge", 32'(n), 32'h0);

    // Bounce on bit 3: 12 toggles at 5-cycle spacing, then settle high.
    seen = 1'b0;
    for (int t = 0; t < 12; t++) begin
      sw_raw[3] = ~sw_raw[3];
      for (int i = 0; i < 5; i++) begin
        step();
        seen = seen | sw_out[3];
      end
    end
    check("bounce_no_pass", 32'(seen), 32'h0);
    check("bounce_hold", 32'(sw_out), 32'h0001);
    sw_raw[3] = 1'b1;
    wait_chg(14'h0001, cyc);
    check("bounce_latency_11_15", 32'(cyc >= 11 && cyc <= 15), 32'h1);
    check("bounce_value", 32'(sw_out), 32'h0009);

    // Bits 0 (fall) and 13 (rise) change together.
    repeat (3) step();
    sw_raw = 14'h2008;
    wait_chg(14'h0009, cyc);
    check("simul_latency_11_15", 32'(cyc >= 11 && cyc <= 15), 32'h1);
    check("simul_same_cycle", 32'(sw_out), 32'h2008);

    // Reset while bit 7 is two ticks into its count.
    repeat (3) step();
    sw_raw = 14'h2088;
    repeat (10) step();
    check("midrst_not_yet", 32'(sw_out), 32'h2008);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_async_out", 32'(sw_out), 32'h0);
    check("midrst_async_tick", 32'(tick), 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("midrst_hold", 32'(sw_out), 32'h0);
    end
    reset = 1'b0;
    wait_chg(14'h0, cyc);
    check("midrst_latency_11_15", 32'(cyc >= 11 && cyc <= 15), 32'h1);
    check("midrst_value", 32'(sw_out), 32'h2088);

    // Bypass: synchroniser delay only; prescaler keeps running.
    bypass = 1'b1;
    sw_raw = 14'h0A5A;
    step();
    step();
    check("byp_cycle2_old", 32'(sw_out), 32'h2088);
    step();
    check("byp_cycle3_new", 32'(sw_out), 32'h0A5A);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      n += int'(tick);
    end
    check("byp_tick_count", 32'(n), 32'h2);
    bypass = 1'b0;
    sw_raw = 14'h0;
    wait_chg(14'h0A5A, cyc);
    check("unbyp_latency_11_15", 32'(cyc >= 11 && cyc <= 15), 32'h1);
    check("unbyp_value", 32'(sw_out), 32'h0);

    // CLK_DIV=1, STABLE_TICKS=1 instance.
    n = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      n += int'(tick_b);
    end
    check("cd1_tick_always", 32'(n), 32'd10);
    sw_raw_b = 14'h0155;
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (sw_out_b == 14'h0 && cyc < 40);
    check("cd1_latency_3_4", 32'(cyc >= 3 && cyc <= 4), 32'h1);
    check("cd1_value", 32'(sw_out_b), 32'h0155);
    check("cd1_tick_still", 32'(tick_b), 32'h1);

`ifdef SW_DEBOUNCE_PULSE_EN
    last5    = sw_out[5];
    n_pulse5 = 0;
    n_bad5   = 0;
    sw_raw[5] = 1'b1;
    watch5(3);
    sw_raw[5] = 1'b0;
    watch5(6);
    check("pulse_glitch_none", 32'(n_pulse5), 32'h0);
    sw_raw[5] = 1'b1;
    watch5(25);
    check("pulse_rise_one", 32'(n_pulse5), 32'h1);
    sw_raw[5] = 1'b0;
    watch5(25);
    check("pulse_fall_one", 32'(n_pulse5), 32'h2);
    check("pulse_aligned", 32'(n_bad5), 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
